q13_seq_detector: RTL and testbench
===================================

// Module: q13_seq_detector
// PURPOSE
//  Serial bit-stream pattern detector. Samples one bit per clock on din and flags
//  when the last three sampled bits form an alternating pattern, either 1-0-1 or
//  0-1-0. Overlapping matches are allowed. Implemented as a Moore FSM with a
//  registered flag output. Standalone leaf block for serial framing/monitor logic.
// PARAMETERS
//  none (fixed 3-bit alternation patterns 101 and 010)
// PORTS
//  clk       input   1  single clock; all state updates on rising edge
//  reset     input   1  asynchronous, active-high reset
//  din       input   1  serial data bit, sampled on each rising clk edge
//  detected  output  1  registered flag; 1 while last 3 sampled bits = 101 or 010
// BEHAVIOUR
//  - Interface (already decided): one clock; reset is asynchronous and active-high.
//  - Reset asserted: state -> IDLE and detected -> 0 immediately, with no clock
//    needed. These values hold while reset stays high.
//  - First sample is taken on the first rising edge where reset is low.
//  - States (Moore). The output is decoded from the next state and registered,
//    so detected always matches the current state.
//    IDLE: no bits yet          0->Z0    1->Z1     det=0
//    Z0: last bit 0, no prefix  0->Z0    1->P01    det=0
//    Z1: last bit 1, no prefix  1->Z1    0->P10    det=0
//    P01: last bits 01          0->D010  1->Z1     det=0
//    P10: last bits 10          1->D101  0->Z0     det=0
//    D101: last bits 101        0->D010  1->Z1     det=1
//    D010: last bits 010        1->D101  0->Z0     det=1
//  - Latency: detected rises at the same rising edge that samples the completing
//    (third) bit, as a flop output. It stays high for exactly one cycle per match.
//  - Overlap: a continuous alternating stream (0101...) keeps detected high on
//    every cycle from the 3rd alternating bit onward.
//  - Any repeated bit (00 or 11) breaks alternation. detected drops on that edge,
//    and a new match needs 3 more alternating bits.
//  - Reset mid-stream discards all history; partial patterns never carry across reset.
//  - Unused state encodings recover to IDLE on the next edge with detected=0.
//  - din is assumed synchronous to clk; no internal synchronizer.
// TESTING
//  1 Reset high for 2 edges, din=0 -> detected=0 throughout; state IDLE.
//  2 After reset, sample din 0,1,0 on 3 edges -> detected=1 after the 3rd edge
//    only; it was 0 after edges 1 and 2.
//  3 Continue with 1,0,1,0 -> detected stays 1 for each of these 4 edges
//    (overlapping 101/010).
//  4 Then din 0,0,1,1 -> detected=0 after the first 0 and stays 0 for all 4 edges.
//  5 Sample 1,0 (now in P10), assert reset asynchronously between edges, release,
//    then sample 1 -> detected stays 0 (history cleared, no 101).
//  6 Hold din=1 for 10 edges, then 0,1 -> detected=0 until the 1 completes 101,
//    then 1 for that single cycle.

Source files
------------

// File: rtl/q13_seq_detector_if.sv
// Serial bit-stream link between a data source and the alternation detector.
interface q13_seq_detector_if;
  logic din;
  logic detected;

  modport master (
    output din,
    input  detected
  );

  modport slave (
    input  din,
    output detected
  );
endinterface

// File: rtl/q13_seq_detector.sv
// Moore FSM that flags whenever the last three sampled bits alternate (101 or 010).
// The flag is decoded from the next state and registered, so it tracks the state register.
module q13_seq_detector (
  input  logic                clk,
  input  logic                reset,
  q13_seq_detector_if.slave   bus
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StZ0   = 3'd1,
    StZ1   = 3'd2,
    StP01  = 3'd3,
    StP10  = 3'd4,
    StD101 = 3'd5,
    StD010 = 3'd6
  } state_e;

  state_e state_q, state_d;
  logic   detected_q, detected_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      detected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      detected_q <= detected_d;
    end
  end

  always_comb begin
    state_d    = StIdle;
    detected_d = 1'b0;
    case (state_q)
      StIdle:  state_d = bus.din ? StZ1   : StZ0;
      StZ0:    state_d = bus.din ? StP01  : StZ0;
      StZ1:    state_d = bus.din ? StZ1   : StP10;
      StP01:   state_d = bus.din ? StZ1   : StD010;
      StP10:   state_d = bus.din ? StD101 : StZ0;
      StD101:  state_d = bus.din ? StZ1   : StD010;
      StD010:  state_d = bus.din ? StD101 : StZ0;
      // The spare encoding falls back to idle with the flag clear.
      default: state_d = StIdle;
    endcase
    detected_d = (state_d == StD101) || (state_d == StD010);
  end

  assign bus.detected = detected_q;

endmodule

// File: tb/tb_q13_seq_detector.sv
// Bench for q13_seq_detector: directed scenarios plus random bits with sporadic resets,
// checked against a history-of-bits reference model.
module tb_q13_seq_detector;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  bit   hist[$];

  q13_seq_detector_if dif ();

  q13_seq_detector u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: detected is high when at least three bits have been sampled since
  // reset and each of the last three differs from its predecessor.
  function automatic logic model_det();
    int n;
    n = hist.size();
    if (n < 3) return 1'b0;
    return (hist[n-1] != hist[n-2]) && (hist[n-2] != hist[n-3]);
  endfunction

  task automatic check(input string tag, input logic exp);
    total++;
    assert (dif.detected === exp)
    else begin
      bad++;
      $error("FAIL %s: detected=%b expected=%b", tag, dif.detected, exp);
    end
  endtask

  // Drive a bit between edges, clock it in, then compare just after the edge.
  task automatic step(input bit b, input string tag);
    dif.din = b;
    @(posedge clk);
    #1;
    if (!reset) hist.push_back(b);
    check(tag, model_det());
  endtask

  task automatic step_exp(input bit b, input string tag, input logic exp);
    step(b, tag);
    total++;
    assert (model_det() === exp)
    else begin
      bad++;
      $error("FAIL %s_model: model=%b expected=%b", tag, model_det(), exp);
    end
  endtask

  // Asynchronous reset: asserted mid-cycle and checked before any edge arrives.
  task automatic async_reset(input int edges, input string tag);
    #2;
    reset = 1'b1;
    hist.delete();
    #1;
    check({tag, "_async"}, 1'b0);
    for (int i = 0; i < edges; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold"}, 1'b0);
    end
    reset = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    dif.din = 1'b0;

    // Reset held for two edges with din low.
    #1;
    check("rst_immediate", 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst_edge", 1'b0);
    end
    reset = 1'b0;

    // 0,1,0 completes the first match only on the third bit.
    step_exp(1'b0, "s2_b0", 1'b0);
    step_exp(1'b1, "s2_b1", 1'b0);
    step_exp(1'b0, "s2_b2", 1'b1);

    // Continuing alternation keeps the flag high (overlapping matches).
    step_exp(1'b1, "s3_b0", 1'b1);
    step_exp(1'b0, "s3_b1", 1'b1);
    step_exp(1'b1, "s3_b2", 1'b1);
    step_exp(1'b0, "s3_b3", 1'b1);

    // A repeated bit breaks alternation immediately.
    step_exp(1'b0, "s4_b0", 1'b0);
    step_exp(1'b0, "s4_b1", 1'b0);
    step_exp(1'b1, "s4_b2", 1'b0);
    step_exp(1'b1, "s4_b3", 1'b0);

    // Flag high, then async reset must clear it without a clock edge.
    step_exp(1'b0, "pre_b0", 1'b0);
    step_exp(1'b1, "pre_b1", 1'b1);
    async_reset(1, "mid_det");

    // Partial 10 must not survive reset into a 101.
    step_exp(1'b1, "s5_b0", 1'b0);
    step_exp(1'b0, "s5_b1", 1'b0);
    async_reset(0, "s5");
    step_exp(1'b1, "s5_b2", 1'b0);

    // Long run of ones, then 0,1 gives a single-cycle pulse.
    for (int i = 0; i < 10; i++) step_exp(1'b1, "s6_ones", 1'b0);
    step_exp(1'b0, "s6_b0", 1'b0);
    step_exp(1'b1, "s6_b1", 1'b1);
    step_exp(1'b1, "s6_b2", 1'b0);

    // Random bits with occasional resets; biased toward alternation for coverage.
    for (int i = 0; i < 400; i++) begin
      bit b;
      if ($urandom_range(0, 39) == 0) async_reset($urandom_range(0, 2), "rnd");
      if (hist.size() > 0 && $urandom_range(0, 3) != 0) b = ~hist[hist.size()-1];
      else b = 1'($urandom_range(0, 1));
      step(b, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
